// File: rtl/duel_round_arbiter.sv
// Two-player reaction round controller: random hold-off, shared stimulus and ms counter,
// first-press arbitration with false-start/timeout detection, and per-match win tallies.
module duel_round_arbiter #(
  parameter int MAX_MS = 999,
  parameter int ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick_1ms,
  input  logic        clear,
  input  logic        start_req,
  input  logic [15:0] delay_ms,
  input  logic        react_a,
  input  logic        react_b,
  output logic        busy,
  output logic        stim_on,
  output logic [9:0]  react_ms,
  output logic [2:0]  result,
  output logic        result_valid,
  output logic [3:0]  wins_a,
  output logic [3:0]  wins_b,
  output logic [3:0]  round_cnt,
  output logic        match_done
);

  typedef enum logic [2:0] {IDLE, ARMED, GO, RESULT, DONE} state_t;

  localparam logic [9:0] MAX_C    = 10'(MAX_MS);
  localparam logic [3:0] ROUNDS_C = 4'(ROUNDS);

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [9:0]  ms_q, ms_d;
  logic [2:0]  res_q, res_d;
  logic        rv_q, rv_d;
  logic [3:0]  wa_q, wa_d, wb_q, wb_d, rc_q, rc_d;
  logic        busy_q, busy_d, stim_q, stim_d, done_q, done_d;
  logic        react_a_q, react_b_q;
  logic        press_a, press_b;
  logic        finish, win_a, win_b;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v >= MAX_C) ? MAX_C : v + 10'd1;
  endfunction

  // Rising-edge detect so a key held from earlier never counts as a new press.
  assign press_a = react_a & ~react_a_q;
  assign press_b = react_b & ~react_b_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ms_d    = ms_q;
    res_d   = res_q;
    rv_d    = 1'b0;
    wa_d    = wa_q;
    wb_d    = wb_q;
    rc_d    = rc_q;
    finish  = 1'b0;
    win_a   = 1'b0;
    win_b   = 1'b0;

    case (state_q)
      IDLE, RESULT: begin
        if (start_req && rc_q < ROUNDS_C) begin
          state_d = ARMED;
          hold_d  = (delay_ms == 16'd0) ? 16'd1 : delay_ms;
          ms_d    = 10'd0;
        end
      end
      ARMED: begin
        // A press beats a coinciding final tick: it is still a false start.
        if (press_a || press_b) begin
          finish = 1'b1;
          res_d  = (press_a && press_b) ? 3'd7 : (press_a ? 3'd5 : 3'd6);
          win_a  = press_b & ~press_a;
          win_b  = press_a & ~press_b;
        end else if (tick_1ms) begin
          if (hold_q <= 16'd1) state_d = GO;
          else                 hold_d  = hold_q - 16'd1;
        end
      end
      GO: begin
        if (press_a || press_b) begin
          finish = 1'b1;
          res_d  = (press_a && press_b) ? 3'd3 : (press_a ? 3'd1 : 3'd2);
          win_a  = press_a & ~press_b;
          win_b  = press_b & ~press_a;
        end else if (ms_q == MAX_C) begin
          finish = 1'b1;
          res_d  = 3'd4;
        end else if (tick_1ms) begin
          ms_d = sat_inc(ms_q);
        end
      end
      default: ;
    endcase

    if (finish) begin
      rv_d    = 1'b1;
      rc_d    = rc_q + 4'd1;
      wa_d    = wa_q + {3'd0, win_a};
      wb_d    = wb_q + {3'd0, win_b};
      state_d = (rc_q + 4'd1 == ROUNDS_C) ? DONE : RESULT;
    end

    if (clear) begin
      state_d = IDLE;
      rv_d    = 1'b0;
      ms_d    = 10'd0;
      res_d   = 3'd0;
      wa_d    = 4'd0;
      wb_d    = 4'd0;
      rc_d    = 4'd0;
    end

    busy_d = (state_d == ARMED) || (state_d == GO);
    stim_d = (state_d == GO);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      hold_q    <= 16'd0;
      ms_q      <= 10'd0;
      res_q     <= 3'd0;
      rv_q      <= 1'b0;
      wa_q      <= 4'd0;
      wb_q      <= 4'd0;
      rc_q      <= 4'd0;
      busy_q    <= 1'b0;
      stim_q    <= 1'b0;
      done_q    <= 1'b0;
      react_a_q <= 1'b0;
      react_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      ms_q      <= ms_d;
      res_q     <= res_d;
      rv_q      <= rv_d;
      wa_q      <= wa_d;
      wb_q      <= wb_d;
      rc_q      <= rc_d;
      busy_q    <= busy_d;
      stim_q    <= stim_d;
      done_q    <= done_d;
      react_a_q <= react_a;
      react_b_q <= react_b;
    end
  end

  assign busy         = busy_q;
  assign stim_on      = stim_q;
  assign react_ms     = ms_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign wins_a       = wa_q;
  assign wins_b       = wb_q;
  assign round_cnt    = rc_q;
  assign match_done   = done_q;

endmodule
